// File: rtl/dic_pkg.sv
// rtl/dic_pkg.sv - alarm message ROM, ASCII constants and FSM state types
package dic_pkg;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  localparam int MSG_ALARM_LEN = 7;

  // Element 0 is the first byte on the wire: "ALARM\r\n"
  localparam logic [MSG_ALARM_LEN-1:0][7:0] MSG_ALARM =
    {ASC_LF, ASC_CR, 8'h4D, 8'h52, 8'h41, 8'h4C, 8'h41};

  typedef enum logic {
    R_IDLE,
    R_RING
  } ring_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

endpackage

// File: rtl/dic_msg_tx.sv
// rtl/dic_msg_tx.sv - ROM-indexed byte serializer over a valid/ready handshake
module dic_msg_tx
  import dic_pkg::*;
#(
  parameter int                     LEN = MSG_ALARM_LEN,
  parameter logic [LEN-1:0][7:0]    ROM = MSG_ALARM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       txReady,
  output logic [7:0] txData,
  output logic       txValid,
  output logic       busy
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

  tx_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      idx_q   <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // A start while sending is ignored, so a frame is never restarted or cut short.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_SEND;
          idx_d   = '0;
          data_d  = ROM[0];
        end
      end
      TX_SEND: begin
        if (txReady) begin
          if (idx_q == IDX_LAST) begin
            state_d = TX_IDLE;
            idx_d   = '0;
            data_d  = 8'h00;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = ROM[idx_d];
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign txData  = data_q;
  assign txValid = (state_q == TX_SEND);
  assign busy    = (state_q == TX_SEND);

endmodule

// File: rtl/dic_alarm_ring.sv
// rtl/dic_alarm_ring.sv - alarm digit match, timed ring with 1 Hz blink, UART alarm message
module dic_alarm_ring
  import dic_pkg::*;
#(
  parameter int RING_SECS = 10,
  parameter int MSG_LEN   = MSG_ALARM_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oneSecStrobe,
  input  logic       dicRun,
  input  logic       alarm_activated,
  input  logic [3:0] dicMtens,
  input  logic [3:0] dicMones,
  input  logic [3:0] dicStens,
  input  logic [3:0] dicSones,
  input  logic [3:0] di_AMtens,
  input  logic [3:0] di_AMones,
  input  logic [3:0] di_AStens,
  input  logic [3:0] di_ASones,
  input  logic       txReady,
  output logic [7:0] txData,
  output logic       txValid,
  output logic       alarm_ring,
  output logic       alarm_blink
);

  ring_state_e ring_state_q, ring_state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        blink_q, blink_d;
  logic        match_prev_q, match_prev_d;
  logic        match;
  logic        trigger;
  logic        tx_busy;

  assign match = alarm_activated & dicRun &
                 (dicMtens == di_AMtens) & (dicMones == di_AMones) &
                 (dicStens == di_AStens) & (dicSones == di_ASones);
  assign match_prev_d = match;
  assign trigger      = match & ~match_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_state_q <= R_IDLE;
      cnt_q        <= 8'd0;
      blink_q      <= 1'b0;
      match_prev_q <= 1'b0;
    end else begin
      ring_state_q <= ring_state_d;
      cnt_q        <= cnt_d;
      blink_q      <= blink_d;
      match_prev_q <= match_prev_d;
    end
  end

  // In R_IDLE strobes are ignored, so a strobe coinciding with the trigger
  // cannot eat into the freshly loaded count.
  always_comb begin
    ring_state_d = ring_state_q;
    cnt_d        = cnt_q;
    blink_d      = blink_q;
    unique case (ring_state_q)
      R_IDLE: begin
        if (trigger) begin
          ring_state_d = R_RING;
          cnt_d        = 8'(RING_SECS);
          blink_d      = 1'b1;
        end
      end
      R_RING: begin
        if (!alarm_activated) begin
          ring_state_d = R_IDLE;
          cnt_d        = 8'd0;
          blink_d      = 1'b0;
        end else if (oneSecStrobe) begin
          if (cnt_q == 8'd1) begin
            ring_state_d = R_IDLE;
            cnt_d        = 8'd0;
            blink_d      = 1'b0;
          end else if (cnt_q != 8'd0) begin
            cnt_d   = cnt_q - 8'd1;
            blink_d = ~blink_q;
          end
        end
      end
      default: ring_state_d = R_IDLE;
    endcase
  end

  assign alarm_ring  = (ring_state_q == R_RING);
  assign alarm_blink = blink_q;

  dic_msg_tx #(
    .LEN (MSG_LEN),
    .ROM (MSG_ALARM)
  ) u_msg_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (trigger & ~tx_busy),
    .txReady (txReady),
    .txData  (txData),
    .txValid (txValid),
    .busy    (tx_busy)
  );

endmodule

// File: tb/tb_dic_alarm_ring.sv
// tb/tb_dic_alarm_ring.sv - directed self-checking bench for dic_alarm_ring
module tb_dic_alarm_ring;

  logic       clk = 1'b0;
  logic       rst;
  logic       oneSecStrobe;
  logic       dicRun;
  logic       alarm_activated;
  logic [3:0] dicMtens, dicMones, dicStens, dicSones;
  logic [3:0] di_AMtens, di_AMones, di_AStens, di_ASones;
  logic       txReady;
  logic [7:0] txData;
  logic       txValid;
  logic       alarm_ring;
  logic       alarm_blink;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_msg [7] = '{8'h41, 8'h4C, 8'h41, 8'h52, 8'h4D, 8'h0D, 8'h0A};

  dic_alarm_ring #(
    .RING_SECS (10),
    .MSG_LEN   (7)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .oneSecStrobe    (oneSecStrobe),
    .dicRun          (dicRun),
    .alarm_activated (alarm_activated),
    .dicMtens        (dicMtens),
    .dicMones        (dicMones),
    .dicStens        (dicStens),
    .dicSones        (dicSones),
    .di_AMtens       (di_AMtens),
    .di_AMones       (di_AMones),
    .di_AStens       (di_AStens),
    .di_ASones       (di_ASones),
    .txReady         (txReady),
    .txData          (txData),
    .txValid         (txValid),
    .alarm_ring      (alarm_ring),
    .alarm_blink     (alarm_blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [3:0] mt, input logic [3:0] mo,
                          input logic [3:0] st, input logic [3:0] so);
    dicMtens = mt; dicMones = mo; dicStens = st; dicSones = so;
  endtask

  initial begin
    rst = 1'b1; oneSecStrobe = 1'b0; dicRun = 1'b0; alarm_activated = 1'b0;
    txReady = 1'b1;
    set_time(4'd0, 4'd0, 4'd0, 4'd0);
    di_AMtens = 4'd0; di_AMones = 4'd1; di_AStens = 4'd3; di_ASones = 4'd0;
    tick(); tick();
    check("rst_ring", alarm_ring, 0);
    check("rst_blink", alarm_blink, 0);
    check("rst_valid", txValid, 0);
    check("rst_data", txData, 8'h00);
    rst = 1'b0;

    // 1+2: 01:29 -> 01:30 with strobe in the trigger cycle, txReady high
    alarm_activated = 1'b1; dicRun = 1'b1;
    set_time(4'd0, 4'd1, 4'd2, 4'd9);
    tick();
    set_time(4'd0, 4'd1, 4'd3, 4'd0); oneSecStrobe = 1'b1;
    tick();
    oneSecStrobe = 1'b0;
    check("t1_ring_on", alarm_ring, 1);
    check("t1_blink_on", alarm_blink, 1);
    check("t2_valid0", txValid, 1);
    check("t2_byte0", txData, exp_msg[0]);
    for (int i = 1; i < 7; i++) begin
      tick();
      check("t2_valid", txValid, 1);
      check($sformatf("t2_byte%0d", i), txData, exp_msg[i]);
    end
    tick();
    check("t2_valid_after", txValid, 0);
    for (int s = 1; s <= 10; s++) begin
      oneSecStrobe = 1'b1; tick();
      oneSecStrobe = 1'b0;
      check($sformatf("t1_ring_s%0d", s), alarm_ring, (s < 10) ? 1 : 0);
      check($sformatf("t1_blink_s%0d", s), alarm_blink, (s < 10 && s % 2 == 0) ? 1 : 0);
      tick();
    end
    check("t1_no_retrigger_tx", txValid, 0);
    set_time(4'd0, 4'd1, 4'd3, 4'd1);
    tick();

    // 3+4: stall on byte 2, cancel at counter 6 during the stall
    set_time(4'd0, 4'd1, 4'd3, 4'd0); oneSecStrobe = 1'b1;
    tick();
    oneSecStrobe = 1'b0;
    check("t3_byte0", txData, 8'h41);
    tick();
    check("t3_byte1", txData, 8'h4C);
    tick();
    check("t3_byte2", txData, 8'h41);
    txReady = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      oneSecStrobe = (k <= 4);
      if (k == 5) alarm_activated = 1'b0;
      tick();
      check($sformatf("t3_stall_valid%0d", k), txValid, 1);
      check($sformatf("t3_stall_data%0d", k), txData, 8'h41);
      check($sformatf("t4_ring%0d", k), alarm_ring, (k < 5) ? 1 : 0);
      check($sformatf("t4_blink%0d", k), alarm_blink, (k < 5 && k % 2 == 0) ? 1 : 0);
    end
    oneSecStrobe = 1'b0; txReady = 1'b1;
    for (int i = 3; i < 7; i++) begin
      tick();
      check($sformatf("t3_resume%0d", i), txData, exp_msg[i]);
      check("t3_resume_valid", txValid, 1);
    end
    tick();
    check("t4_msg_done", txValid, 0);
    check("t4_ring_off", alarm_ring, 0);

    // 5: no ring when disabled or stopped; held match triggers once
    set_time(4'd0, 4'd1, 4'd2, 4'd9);
    tick();
    set_time(4'd0, 4'd1, 4'd3, 4'd0);
    tick(); tick();
    check("t5_noact_ring", alarm_ring, 0);
    check("t5_noact_valid", txValid, 0);
    dicRun = 1'b0; alarm_activated = 1'b1;
    tick(); tick();
    check("t5_norun_ring", alarm_ring, 0);
    check("t5_norun_valid", txValid, 0);
    dicRun = 1'b1;
    tick();
    check("t5_held_ring", alarm_ring, 1);
    check("t5_held_valid", txValid, 1);
    for (int i = 0; i < 7; i++) tick();
    for (int i = 0; i < 20; i++) begin
      if (txValid !== 1'b0) break;
      tick();
    end
    check("t5_single_trigger", txValid, 0);
    check("t5_still_ring", alarm_ring, 1);

    // 6: reset during byte 3 with ring active
    set_time(4'd0, 4'd1, 4'd3, 4'd1);
    tick();
    set_time(4'd0, 4'd1, 4'd3, 4'd0);
    tick();
    check("t6_byte0", txData, 8'h41);
    tick(); tick(); tick();
    check("t6_byte3", txData, 8'h52);
    check("t6_ring_pre", alarm_ring, 1);
    rst = 1'b1;
    set_time(4'd0, 4'd1, 4'd3, 4'd1);
    tick();
    check("t6_ring", alarm_ring, 0);
    check("t6_blink", alarm_blink, 0);
    check("t6_valid", txValid, 0);
    check("t6_data", txData, 8'h00);
    rst = 1'b0;
    tick(); tick(); tick();
    check("t6_no_more_valid", txValid, 0);
    check("t6_no_more_ring", alarm_ring, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
